store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Post-retirement write buffer between the store queue's retire write-back outputs and the data-memory port.
- Accepts up to 3 retired stores per cycle, holds them in program order, and drains them one at a time to memory over a valid/ready handshake.
- Also provides store-to-load forwarding and blocking for the load unit, so a younger load never reads stale memory.

Parameters:
- CB_IDX, 3, log2 of buffer depth; depth DEPTH = 2**CB_IDX = 8 entries.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- wb_valid  in  3  retired-store valid per slot; slot 2 oldest, slot 0 youngest
- wb_store  in  3 x SQ_ENTRY_PACKET  retired store {addr[31:0], data[31:0], size MEM_SIZE, valid}
- retire_stall  out  3  per-slot stall, same encoding as the store-queue struct_stall
- mem_req_valid  out  1  head entry presented to memory
- mem_req_addr  out  32  head address
- mem_req_data  out  32  head data, lane-aligned
- mem_req_size  out  2  head MEM_SIZE
- mem_req_ready  in  1  memory accepts the request this cycle
- ld_addr  in  32  load lookup address
- ld_size  in  2  load MEM_SIZE
- ld_fwd_valid  out  1  forwarding hit
- ld_fwd_data  out  32  word with forwarded bytes in their lanes
- ld_block  out  1  load must replay: partial overlap
- empty  out  1  buffer holds no entries (used for halt drain)

Behaviour:
- Storage: circular FIFO with a head (oldest) pointer, a tail (next free) pointer and a count[CB_IDX:0]. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset: head = tail = count = 0, all entries cleared. Outputs after reset: mem_req_valid = 0, empty = 1, ld_fwd_valid = 0, ld_block = 0, retire_stall = 3'b000.
- Reset asserted mid-drain discards all entries. mem_req_valid drops the following cycle; memory must tolerate an abandoned request.
- Stall:
  - free = DEPTH - registered count. There is no same-cycle credit for a dequeue, which keeps mem_req_ready off the stall path.
  - free = 0 -> 3'b111; free = 1 -> 3'b011; free = 2 -> 3'b001; otherwise 3'b000.
  - Upstream never asserts wb_valid on a stalled slot. The bench asserts this; the RTL need not handle it.
- Enqueue:
  - Valid slots are written in order 2, 1, 0, skipping invalid slots and compacting into consecutive tail entries.
  - tail advances by popcount(wb_valid). Entries are visible from the next cycle.
- Drain:
  - mem_req_valid = (count != 0), driven combinationally from the registered head entry.
  - Request fields stay stable while mem_req_valid && !mem_req_ready.
  - On valid && ready, the head entry is cleared, head increments and count decrements at the clock edge. One dequeue per cycle maximum; zero-cycle latency from head to request.
- Simultaneous enqueue and dequeue: next count = count + popcount(wb_valid) - deq. When full (count = 8), a dequeue in the same cycle frees space only from the next cycle.
- empty = (count == 0), registered state only.
- Byte masks:
  - Store: BYTE -> 4'b0001 << addr[1:0]; HALF -> 4'b0011 << addr[1:0]; WORD -> 4'b1111.
  - Load mask is formed the same way.
- Overlap: an entry overlaps the load when addr[31:2] matches and (store mask & load mask) != 0.
- Forwarding (combinational):
  - Candidates are all buffered entries plus this cycle's valid wb_store slots.
  - Youngest-first priority: wb slot 0, slot 1, slot 2, then buffer entries from tail-1 back to head.
  - Only the youngest overlapping candidate decides:
    - If it covers all load bytes: ld_fwd_valid = 1, ld_fwd_data = its data, ld_block = 0.
    - Otherwise: ld_block = 1, ld_fwd_valid = 0.
  - Bytes are not merged across multiple stores.
  - No overlap: both flags 0 and ld_fwd_data = 0.

Decomposition:
- Shared package: SQ_ENTRY_PACKET, MEM_SIZE enum (BYTE = 0, HALF = 1, WORD = 2), and the function that builds a byte mask from size and addr[1:0].
- One natural sub-module: cb_fwd_search, the youngest-first overlap priority search returning hit, block and data. The FIFO logic stays in the top module.

Test Plan:
- Reset, then wb_valid = 3'b111 with WORD stores to 0x100, 0x104, 0x108 and mem_req_ready = 1 -> next cycle mem_req_addr = 0x100; then 0x104 and 0x108 on consecutive cycles; empty = 1 after the third handshake.
- mem_req_ready = 0 and 8 stores enqueued over 3 cycles -> retire_stall goes 000, then 001 at count = 6, then 111 at count = 8. Hold ready = 0 for 5 cycles -> request fields unchanged.
- wb_valid = 3'b101 (slot 2 addr 0x200, slot 0 addr 0x204) -> buffer entries in that order; count increases by exactly 2.
- Buffered WORD 0x300 = 0xAABBCCDD; load BYTE at 0x302 -> ld_fwd_valid = 1, ld_fwd_data = 0xAABBCCDD.
- Buffered BYTE at 0x401 and a younger WORD 0x400 arriving this cycle; load HALF at 0x400 -> forward from the WORD. Swap ages -> ld_block = 1.
- Full buffer with dequeue and 1 wb in the same cycle while stall = 111 -> the wb is illegal and flagged by the assertion. With count = 7, dequeue plus 1 wb -> count stays 7 and pointers wrap correctly past index 7.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-retirement store commit buffer: store packet, access size
// and the byte-lane mask helper used by both the FIFO and the forwarding search.
package store_commit_buffer_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } MEM_SIZE;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        MEM_SIZE     size;
        logic        valid;
    } SQ_ENTRY_PACKET;

    function automatic logic [3:0] byte_mask(input MEM_SIZE size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            BYTE:    mask = 4'b0001 << offset;
            HALF:    mask = 4'b0011 << offset;
            WORD:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bundle of retire write-back, memory request, load lookup and status signals.
// slave is the buffer side, master is the surrounding pipeline / memory side.
interface store_commit_buffer_if;
    import store_commit_buffer_pkg::*;

    logic [2:0]           wb_valid;
    SQ_ENTRY_PACKET [2:0] wb_store;
    logic [2:0]           retire_stall;

    logic                 mem_req_valid;
    logic [31:0]          mem_req_addr;
    logic [31:0]          mem_req_data;
    MEM_SIZE              mem_req_size;
    logic                 mem_req_ready;

    logic [31:0]          ld_addr;
    MEM_SIZE              ld_size;
    logic                 ld_fwd_valid;
    logic [31:0]          ld_fwd_data;
    logic                 ld_block;

    logic                 empty;

    modport slave (
        input  wb_valid, wb_store, mem_req_ready, ld_addr, ld_size,
        output retire_stall, mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
        output ld_fwd_valid, ld_fwd_data, ld_block, empty
    );

    modport master (
        output wb_valid, wb_store, mem_req_ready, ld_addr, ld_size,
        input  retire_stall, mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
        input  ld_fwd_valid, ld_fwd_data, ld_block, empty
    );

endinterface

// File: rtl/store_commit_buffer_cb_fwd_search.sv
// Youngest-first store-to-load overlap search over buffered entries and this cycle's
// write-back slots; purely combinational, only the youngest overlapping store decides.
module cb_fwd_search
    import store_commit_buffer_pkg::*;
#(
    parameter int CB_IDX = 3
) (
    input  logic [31:0]                   ld_addr,
    input  MEM_SIZE                       ld_size,
    input  SQ_ENTRY_PACKET [2:0]          wb_cand,
    input  SQ_ENTRY_PACKET [2**CB_IDX-1:0] entries,
    input  logic [CB_IDX-1:0]             head,
    input  logic [CB_IDX:0]               count,
    output logic                          hit,
    output logic                          block,
    output logic [31:0]                   data
);

    localparam int DEPTH = 2**CB_IDX;

    logic [3:0]        ld_mask;
    logic              found;
    logic [3:0]        sel_mask;
    logic [31:0]       sel_data;
    logic [CB_IDX-1:0] idx;

    function automatic logic overlaps(input SQ_ENTRY_PACKET e, input logic [31:0] a,
                                      input logic [3:0] lm);
        return e.valid && (e.addr[31:2] == a[31:2]) &&
               ((byte_mask(e.size, e.addr[1:0]) & lm) != 4'b0000);
    endfunction

    // Scan oldest to youngest so that each later match overrides the earlier one.
    always_comb begin
        ld_mask  = byte_mask(ld_size, ld_addr[1:0]);
        found    = 1'b0;
        sel_mask = 4'b0000;
        sel_data = 32'h0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + CB_IDX'(i);
            if (((CB_IDX+1)'(i) < count) && overlaps(entries[idx], ld_addr, ld_mask)) begin
                found    = 1'b1;
                sel_mask = byte_mask(entries[idx].size, entries[idx].addr[1:0]);
                sel_data = entries[idx].data;
            end
        end
        for (int s = 2; s >= 0; s--) begin
            if (overlaps(wb_cand[s], ld_addr, ld_mask)) begin
                found    = 1'b1;
                sel_mask = byte_mask(wb_cand[s].size, wb_cand[s].addr[1:0]);
                sel_data = wb_cand[s].data;
            end
        end
    end

    assign hit   = found && ((sel_mask & ld_mask) == ld_mask);
    assign block = found && !hit;
    assign data  = hit ? sel_data : 32'h0;

endmodule

// File: rtl/store_commit_buffer.sv
// Post-retirement store FIFO: up to 3 enqueues per cycle in program order, one drain per
// valid/ready handshake with zero-latency head presentation, plus load forwarding/blocking.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int CB_IDX = 3
) (
    input logic                  clock,
    input logic                  reset,
    store_commit_buffer_if.slave bus
);

    localparam int DEPTH = 2**CB_IDX;

    SQ_ENTRY_PACKET [DEPTH-1:0] entries;
    logic [CB_IDX-1:0]          head;
    logic [CB_IDX-1:0]          tail;
    logic [CB_IDX:0]            count;
    logic [CB_IDX:0]            free;
    SQ_ENTRY_PACKET [2:0]       wb_cand;
    logic [CB_IDX-1:0]          slot_idx [3];
    logic [1:0]                 n_enq;
    logic                       deq;

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            wb_cand[s]       = bus.wb_store[s];
            wb_cand[s].valid = bus.wb_valid[s];
        end
    end

    // Stall looks only at registered occupancy so mem_req_ready never reaches retire.
    assign free = (CB_IDX+1)'(DEPTH) - count;

    always_comb begin
        if (free == (CB_IDX+1)'(0))      bus.retire_stall = 3'b111;
        else if (free == (CB_IDX+1)'(1)) bus.retire_stall = 3'b011;
        else if (free == (CB_IDX+1)'(2)) bus.retire_stall = 3'b001;
        else                             bus.retire_stall = 3'b000;
    end

    // Valid slots compact into consecutive tail entries, oldest slot (2) first.
    assign n_enq       = {1'b0, bus.wb_valid[2]} + {1'b0, bus.wb_valid[1]} + {1'b0, bus.wb_valid[0]};
    assign slot_idx[2] = tail;
    assign slot_idx[1] = tail + CB_IDX'(bus.wb_valid[2]);
    assign slot_idx[0] = tail + CB_IDX'(bus.wb_valid[2]) + CB_IDX'(bus.wb_valid[1]);

    assign bus.mem_req_valid = (count != '0);
    assign bus.mem_req_addr  = entries[head].addr;
    assign bus.mem_req_data  = entries[head].data;
    assign bus.mem_req_size  = entries[head].size;
    assign bus.empty         = (count == '0);
    assign deq               = bus.mem_req_valid && bus.mem_req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (deq) begin
                entries[head] <= '0;
                head          <= head + CB_IDX'(1);
            end
            for (int s = 2; s >= 0; s--) begin
                if (bus.wb_valid[s]) begin
                    entries[slot_idx[s]] <= wb_cand[s];
                end
            end
            tail  <= tail + CB_IDX'(n_enq);
            count <= count + (CB_IDX+1)'(n_enq) - (CB_IDX+1)'(deq);
        end
    end

    cb_fwd_search #(
        .CB_IDX (CB_IDX)
    ) u_fwd_search (
        .ld_addr (bus.ld_addr),
        .ld_size (bus.ld_size),
        .wb_cand (wb_cand),
        .entries (entries),
        .head    (head),
        .count   (count),
        .hit     (bus.ld_fwd_valid),
        .block   (bus.ld_block),
        .data    (bus.ld_fwd_data)
    );

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: drain order, stall encoding, slot compaction,
// forwarding priority, pointer wrap and reset mid-drain.
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    store_commit_buffer_if bus();

    store_commit_buffer #(.CB_IDX(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic SQ_ENTRY_PACKET mk(input logic [31:0] a, input logic [31:0] d, input MEM_SIZE s);
        SQ_ENTRY_PACKET p;
        p.addr  = a;
        p.data  = d;
        p.size  = s;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Upstream must never present a store on a stalled slot.
    always @(posedge clock) begin
        if (!reset && bus.wb_valid != 3'b000) begin
            n_checks++;
            if ((bus.wb_valid & bus.retire_stall) != 3'b000)
                $display("FAIL wb_on_stalled_slot wb_valid=%b retire_stall=%b", bus.wb_valid, bus.retire_stall);
            else
                n_pass++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid got %b want 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.ld_fwd_valid !== 1'b0) $display("FAIL reset_ld_fwd_valid got %b want 0", bus.ld_fwd_valid); else n_pass++;
        n_checks++; if (bus.ld_block !== 1'b0) $display("FAIL reset_ld_block got %b want 0", bus.ld_block); else n_pass++;
        n_checks++; if (bus.retire_stall !== 3'b000) $display("FAIL reset_retire_stall got %b want 000", bus.retire_stall); else n_pass++;
    endtask

    task automatic test_drain();
        bus.mem_req_ready = 1'b1;
        bus.wb_valid      = 3'b111;
        bus.wb_store[2]   = mk(32'h100, 32'hA0, WORD);
        bus.wb_store[1]   = mk(32'h104, 32'hA1, WORD);
        bus.wb_store[0]   = mk(32'h108, 32'hA2, WORD);
        step();
        bus.wb_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL drain_valid%0d got %b want 1", k, bus.mem_req_valid); else n_pass++;
            n_checks++; if (bus.mem_req_addr !== 32'h100 + 32'(4*k)) $display("FAIL drain_addr%0d got %h want %h", k, bus.mem_req_addr, 32'h100 + 32'(4*k)); else n_pass++;
            n_checks++; if (bus.mem_req_data !== 32'hA0 + 32'(k)) $display("FAIL drain_data%0d got %h want %h", k, bus.mem_req_data, 32'hA0 + 32'(k)); else n_pass++;
            step();
        end
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL drain_idle_valid got %b want 0", bus.mem_req_valid); else n_pass++;
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus.mem_req_ready = 1'b0;
        bus.wb_valid      = 3'b111;
        bus.wb_store[2]   = mk(32'h500, 32'hD000_0000, WORD);
        bus.wb_store[1]   = mk(32'h504, 32'hD000_0001, WORD);
        bus.wb_store[0]   = mk(32'h508, 32'hD000_0002, WORD);
        n_checks++; if (bus.retire_stall !== 3'b000) $display("FAIL stall_cnt0 got %b want 000", bus.retire_stall); else n_pass++;
        step();
        n_checks++; if (bus.retire_stall !== 3'b000) $display("FAIL stall_cnt3 got %b want 000", bus.retire_stall); else n_pass++;
        bus.wb_store[2] = mk(32'h50C, 32'hD000_0003, WORD);
        bus.wb_store[1] = mk(32'h510, 32'hD000_0004, WORD);
        bus.wb_store[0] = mk(32'h514, 32'hD000_0005, WORD);
        step();
        n_checks++; if (bus.retire_stall !== 3'b001) $display("FAIL stall_cnt6 got %b want 001", bus.retire_stall); else n_pass++;
        bus.wb_valid    = 3'b110;
        bus.wb_store[2] = mk(32'h518, 32'hD000_0006, WORD);
        bus.wb_store[1] = mk(32'h51C, 32'hD000_0007, WORD);
        step();
        bus.wb_valid = 3'b000;
        n_checks++; if (bus.retire_stall !== 3'b111) $display("FAIL stall_cnt8 got %b want 111", bus.retire_stall); else n_pass++;
        n_checks++; if (bus.empty !== 1'b0) $display("FAIL stall_full_empty got %b want 0", bus.empty); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.mem_req_addr !== 32'h500) $display("FAIL hold_addr%0d got %h want 00000500", c, bus.mem_req_addr); else n_pass++;
            n_checks++; if (bus.mem_req_data !== 32'hD000_0000) $display("FAIL hold_data%0d got %h want d0000000", c, bus.mem_req_data); else n_pass++;
            n_checks++; if (bus.mem_req_size !== WORD) $display("FAIL hold_size%0d got %0d want 2", c, bus.mem_req_size); else n_pass++;
            step();
        end
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus.mem_req_addr !== 32'h500 + 32'(4*k)) $display("FAIL full_drain_addr%0d got %h want %h", k, bus.mem_req_addr, 32'h500 + 32'(4*k)); else n_pass++;
            step();
        end
        bus.mem_req_ready = 1'b0;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL full_drain_empty got %b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_compact();
        bus.mem_req_ready = 1'b0;
        bus.wb_valid      = 3'b101;
        bus.wb_store[2]   = mk(32'h200, 32'hC2, WORD);
        bus.wb_store[1]   = mk(32'h999, 32'hBAD, WORD);
        bus.wb_store[0]   = mk(32'h204, 32'hC0, WORD);
        step();
        bus.wb_valid = 3'b000;
        n_checks++; if (bus.mem_req_addr !== 32'h200) $display("FAIL compact_first got %h want 00000200", bus.mem_req_addr); else n_pass++;
        bus.mem_req_ready = 1'b1;
        step();
        n_checks++; if (bus.mem_req_addr !== 32'h204) $display("FAIL compact_second got %h want 00000204", bus.mem_req_addr); else n_pass++;
        n_checks++; if (bus.mem_req_data !== 32'hC0) $display("FAIL compact_second_data got %h want 000000c0", bus.mem_req_data); else n_pass++;
        step();
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL compact_count got empty=%b want 1", bus.empty); else n_pass++;
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_fwd_word();
        bus.wb_valid    = 3'b001;
        bus.wb_store[0] = mk(32'h300, 32'hAABB_CCDD, WORD);
        step();
        bus.wb_valid = 3'b000;
        bus.ld_addr  = 32'h302;
        bus.ld_size  = BYTE;
        #1;
        n_checks++; if (bus.ld_fwd_valid !== 1'b1) $display("FAIL fwd_byte_hit got %b want 1", bus.ld_fwd_valid); else n_pass++;
        n_checks++; if (bus.ld_fwd_data !== 32'hAABB_CCDD) $display("FAIL fwd_byte_data got %h want aabbccdd", bus.ld_fwd_data); else n_pass++;
        n_checks++; if (bus.ld_block !== 1'b0) $display("FAIL fwd_byte_block got %b want 0", bus.ld_block); else n_pass++;
        bus.ld_addr = 32'h306;
        #1;
        n_checks++; if ({bus.ld_fwd_valid, bus.ld_block} !== 2'b00) $display("FAIL fwd_miss_flags got %b want 00", {bus.ld_fwd_valid, bus.ld_block}); else n_pass++;
        n_checks++; if (bus.ld_fwd_data !== 32'h0) $display("FAIL fwd_miss_data got %h want 00000000", bus.ld_fwd_data); else n_pass++;
        bus.ld_addr = 32'h300;
        bus.ld_size = WORD;
        #1;
        n_checks++; if (bus.ld_fwd_valid !== 1'b1) $display("FAIL fwd_word_hit got %b want 1", bus.ld_fwd_valid); else n_pass++;
        bus.ld_addr       = 32'h0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_fwd_age();
        bus.wb_valid    = 3'b001;
        bus.wb_store[0] = mk(32'h401, 32'h0000_EE00, BYTE);
        step();
        bus.wb_valid = 3'b000;
        bus.ld_addr  = 32'h400;
        bus.ld_size  = HALF;
        #1;
        n_checks++; if ({bus.ld_fwd_valid, bus.ld_block} !== 2'b01) $display("FAIL age_partial_buf got %b want 01", {bus.ld_fwd_valid, bus.ld_block}); else n_pass++;
        bus.wb_valid    = 3'b001;
        bus.wb_store[0] = mk(32'h400, 32'h1234_5678, WORD);
        #1;
        n_checks++; if (bus.ld_fwd_valid !== 1'b1) $display("FAIL age_young_word_hit got %b want 1", bus.ld_fwd_valid); else n_pass++;
        n_checks++; if (bus.ld_fwd_data !== 32'h1234_5678) $display("FAIL age_young_word_data got %h want 12345678", bus.ld_fwd_data); else n_pass++;
        n_checks++; if (bus.ld_block !== 1'b0) $display("FAIL age_young_word_block got %b want 0", bus.ld_block); else n_pass++;
        bus.wb_valid      = 3'b000;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.wb_valid      = 3'b001;
        bus.wb_store[0]   = mk(32'h400, 32'h1234_5678, WORD);
        step();
        bus.wb_store[0] = mk(32'h401, 32'h0000_EE00, BYTE);
        #1;
        n_checks++; if ({bus.ld_fwd_valid, bus.ld_block} !== 2'b01) $display("FAIL age_young_byte_wb got %b want 01", {bus.ld_fwd_valid, bus.ld_block}); else n_pass++;
        step();
        bus.wb_valid = 3'b000;
        #1;
        n_checks++; if ({bus.ld_fwd_valid, bus.ld_block} !== 2'b01) $display("FAIL age_young_byte_buf got %b want 01", {bus.ld_fwd_valid, bus.ld_block}); else n_pass++;
        bus.mem_req_ready = 1'b1;
        step();
        step();
        bus.mem_req_ready = 1'b0;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL age_drained got empty=%b want 1", bus.empty); else n_pass++;
        bus.wb_valid    = 3'b101;
        bus.wb_store[2] = mk(32'h401, 32'h0000_EE00, BYTE);
        bus.wb_store[0] = mk(32'h400, 32'h1234_5678, WORD);
        #1;
        n_checks++; if (bus.ld_fwd_data !== 32'h1234_5678) $display("FAIL age_slot0_priority got %h want 12345678", bus.ld_fwd_data); else n_pass++;
        bus.wb_valid = 3'b000;
        bus.ld_addr  = 32'h0;
        bus.ld_size  = BYTE;
    endtask

    task automatic test_wrap();
        bus.mem_req_ready = 1'b0;
        bus.wb_valid      = 3'b111;
        bus.wb_store[2]   = mk(32'h600, 32'hE0, WORD);
        bus.wb_store[1]   = mk(32'h604, 32'hE1, WORD);
        bus.wb_store[0]   = mk(32'h608, 32'hE2, WORD);
        step();
        bus.wb_store[2] = mk(32'h60C, 32'hE3, WORD);
        bus.wb_store[1] = mk(32'h610, 32'hE4, WORD);
        bus.wb_store[0] = mk(32'h614, 32'hE5, WORD);
        step();
        bus.wb_valid    = 3'b100;
        bus.wb_store[2] = mk(32'h618, 32'hE6, WORD);
        step();
        n_checks++; if (bus.retire_stall !== 3'b011) $display("FAIL wrap_cnt7_stall got %b want 011", bus.retire_stall); else n_pass++;
        bus.mem_req_ready = 1'b1;
        bus.wb_store[2]   = mk(32'h61C, 32'hE7, WORD);
        step();
        bus.mem_req_ready = 1'b0;
        bus.wb_valid      = 3'b000;
        n_checks++; if (bus.retire_stall !== 3'b011) $display("FAIL wrap_cnt_stays7 got %b want 011", bus.retire_stall); else n_pass++;
        bus.mem_req_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            n_checks++; if (bus.mem_req_data !== 32'hE0 + 32'(k)) $display("FAIL wrap_order%0d got %h want %h", k, bus.mem_req_data, 32'hE0 + 32'(k)); else n_pass++;
            step();
        end
        bus.mem_req_ready = 1'b0;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_req_ready = 1'b1;
        bus.wb_valid      = 3'b111;
        bus.wb_store[2]   = mk(32'h700, 32'hF0, WORD);
        bus.wb_store[1]   = mk(32'h704, 32'hF1, WORD);
        bus.wb_store[0]   = mk(32'h708, 32'hF2, WORD);
        step();
        bus.wb_valid = 3'b000;
        n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", bus.mem_req_valid); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL mid_reset_empty got %b want 1", bus.empty); else n_pass++;
        bus.wb_valid    = 3'b001;
        bus.wb_store[0] = mk(32'h800, 32'hF8, WORD);
        step();
        bus.wb_valid = 3'b000;
        n_checks++; if (bus.mem_req_addr !== 32'h800) $display("FAIL mid_restart_head got %h want 00000800", bus.mem_req_addr); else n_pass++;
        step();
        bus.mem_req_ready = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        reset             = 1'b1;
        bus.wb_valid      = 3'b000;
        bus.wb_store      = '0;
        bus.mem_req_ready = 1'b0;
        bus.ld_addr       = 32'h0;
        bus.ld_size       = BYTE;
        test_reset();
        test_drain();
        test_stall();
        test_compact();
        test_fwd_word();
        test_fwd_age();
        test_wrap();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
